fir_unity_inverse: RTL and testbench
====================================

Name: fir_unity_inverse

Overview:
- Inverse (decoder) of the team's unity-coefficient FIR filter `filterfir`.
- Forward filter: y[n] = x[n] + x[n-1] + ... + x[n-TAPS+1], with a zero-initialised delay line.
- This block takes the filter's OW-bit output stream and recursively recovers the original DW-bit samples: x[n] = y[n] - (x[n-1] + ... + x[n-TAPS+1]).
- It sits after the FIR in loopback and self-check paths and flags streams that could not have come from the forward filter.

Parameters:
- DW, 8, recovered sample width (unsigned).
- TAPS, 4, number of unity taps in the forward filter (≥2).
- OW, DW+$clog2(TAPS) = 10, input width (forward filter output).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  OW  forward-filter output sample (unsigned).
- din_valid  in  1  din is a new sample this cycle.
- resync  in  1  single-cycle pulse: clear history, leave FAULT.
- dout  out  DW  recovered sample.
- dout_valid  out  1  dout updated this cycle.
- err  out  1  sticky fault indicator (high while in FAULT).
- count  out  16  number of samples accepted since reset/resync; wraps 0xFFFF→0.

Behaviour:
- Reset, sampled on the clk edge with rst=1:
  - state=RUN; dout=0, dout_valid=0, err=0, count=0.
  - History registers h[0..TAPS-2] = 0.
  - rst overrides every other input, including mid-stream.
- History holds the last TAPS-1 recovered samples; h[0] is the newest. A running sum S = Σh (width OW) is kept as a register, not re-added each cycle.
- Compute, in RUN with din_valid=1:
  - d = din - S, signed, OW+1 bits.
  - If 0 ≤ d ≤ 2^DW-1: r = d[DW-1:0].
  - If d < 0: r = 0, enter FAULT.
  - If d > 2^DW-1: r = 2^DW-1, enter FAULT.
- Update on the same edge:
  - dout = r; dout_valid = 1.
  - History shifts: h[0]=r, h[k]=h[k-1], h[TAPS-2] is dropped.
  - S = S + r - h[TAPS-2] (old value).
  - count += 1.
- Latency: dout appears exactly 1 clk after the din_valid cycle. Throughput is 1 sample per clock.
- din_valid=0: dout_valid=0; dout, history, S and count hold.
- State machine has two states: RUN and FAULT.
  - RUN→FAULT: out-of-range d on a valid cycle. That sample is still output (clamped) with dout_valid=1, and err goes 1 on the same edge.
  - In FAULT:
    - Inputs are consumed but not decoded: dout_valid=0, history frozen, count holds, err=1.
  - FAULT→RUN: only on resync=1. This clears h, S and count to 0, sets err=0 and drops any din on that cycle (dout_valid=0).
  - resync in RUN: same clearing, stays in RUN, drops the din on that cycle.
- Simultaneous events: rst > resync > din_valid.
- All arithmetic is unsigned except d. No truncation of S, because S ≤ (TAPS-1)(2^DW-1) < 2^OW.

Decomposition:
- Shared package `fir_pkg`:
  - DW, TAPS, OW localparams.
  - State enum {RUN, FAULT}.
  - Function clamp_u(signed d) returning DW bits plus an out-of-range flag.
  - This package is also used by `filterfir` so widths stay consistent.
- One sub-module, `fir_history`: TAPS-1 deep shift register plus running-sum register, with ports shift_en, clear, new_sample, sum.
- Top level holds the FSM, subtractor/clamp and count.

Test Plan:
- Loopback: rst 1 cycle, then din=5,15,27,42,53 on consecutive valid cycles (forward output of 5,10,12,15,16) -> dout=5,10,12,15,16, each 1 clk later; err=0; count=5.
- Valid gaps: same stream with din_valid low for 3 cycles between samples -> identical dout sequence; dout_valid low during gaps; dout holds 10 through gap after second sample.
- Underflow: after reset din=5 then din=2 -> second dout=0, dout_valid=1, err=1; further din=100 -> dout_valid=0, dout stays 0, count=2.
- Overflow and resync: after reset din=300 -> dout=255, err=1. Pulse resync with din=7, din_valid=1 -> no output, err=0, count=0. Then din=7 -> dout=7.
- Reset mid-stream: feed 5,15 then rst with din_valid=1 -> dout=0, dout_valid=0, count=0. Then din=10 -> dout=10 (history cleared, not 0).
- Wrap: force 65535 accepted samples of din=0 -> count=0xFFFF; one more -> count=0, err=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, FSM state type and clamp helper for the unity-coefficient FIR
// and its inverse, so both ends of a loopback agree on sample widths.
package fir_pkg;

    localparam int unsigned DW   = 8;
    localparam int unsigned TAPS = 4;
    localparam int unsigned OW   = DW + $clog2(TAPS);

    typedef enum logic {RUN, FAULT} state_t;

    typedef struct packed {
        logic [DW-1:0] val;
        logic          oor;
    } clamp_t;

    // Saturate a signed difference into the unsigned sample range.
    function automatic clamp_t clamp_u(input logic signed [OW:0] d);
        clamp_t c;
        if (d[OW]) begin
            c.val = '0;
            c.oor = 1'b1;
        end else if (|d[OW-1:DW]) begin
            c.val = '1;
            c.oor = 1'b1;
        end else begin
            c.val = d[DW-1:0];
            c.oor = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/fir_history.sv
// Last TAPS-1 recovered samples (h[0] newest) plus a running sum register that
// is updated incrementally instead of re-adding the whole line each cycle.
module fir_history
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_en,
    input  logic          clear,
    input  logic [DW-1:0] new_sample,
    output logic [OW-1:0] sum
);

    logic [DW-1:0] h_q [TAPS-1];
    logic [OW-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < int'(TAPS) - 1; k++) begin
                h_q[k] <= '0;
            end
            sum_q <= '0;
        end else if (shift_en) begin
            h_q[0] <= new_sample;
            for (int k = 1; k < int'(TAPS) - 1; k++) begin
                h_q[k] <= h_q[k-1];
            end
            // Intermediate may wrap modulo 2^OW; the true result always fits.
            sum_q <= sum_q + OW'(new_sample) - OW'(h_q[TAPS-2]);
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/fir_unity_inverse.sv
// Recursive decoder for the unity-tap FIR: x[n] = y[n] - sum of the previous
// TAPS-1 recovered samples, with saturation and a sticky fault state.
module fir_unity_inverse
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [OW-1:0] din,
    input  logic          din_valid,
    input  logic          resync,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          err,
    output logic [15:0]   count
);

    state_t              state_q, state_d;
    logic [OW-1:0]       sum;
    logic signed [OW:0]  d;
    clamp_t              cl;
    logic                accept;
    logic [DW-1:0]       dout_q;
    logic                dout_valid_q;
    logic [15:0]         count_q;

    always_comb begin
        accept  = din_valid && !resync && (state_q == RUN);
        d       = $signed({1'b0, din}) - $signed({1'b0, sum});
        cl      = clamp_u(d);
        state_d = state_q;
        if (resync) begin
            state_d = RUN;
        end else if (accept && cl.oor) begin
            state_d = FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            dout_valid_q <= accept;
            if (accept) begin
                dout_q <= cl.val;
            end
            if (resync) begin
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    fir_history u_history (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (accept),
        .clear      (resync),
        .new_sample (cl.val),
        .sum        (sum)
    );

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign err        = (state_q == FAULT);
    assign count      = count_q;

endmodule

// File: tb/tb_fir_unity_inverse.sv
// Self-checking bench: every-cycle comparison against a sample-level model of
// the inverse filter, plus directed vectors with literal expectations.
module tb_fir_unity_inverse;
    import fir_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [OW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          resync = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          err;
    logic [15:0]   count;

    int total  = 0;
    int passed = 0;

    fir_unity_inverse dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .resync     (resync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: recovered samples kept as plain integers, newest first.
    int m_hist [TAPS-1];
    int m_dout, m_count;
    bit m_dv, m_fault, m_live;
    int got [$];

    always @(posedge clk) begin
        int s, dd, r;
        if (rst) begin
            foreach (m_hist[k]) m_hist[k] = 0;
            m_fault = 0; m_count = 0; m_dout = 0; m_dv = 0; m_live = 1;
        end else if (resync) begin
            foreach (m_hist[k]) m_hist[k] = 0;
            m_fault = 0; m_count = 0; m_dv = 0;
        end else if (din_valid && !m_fault) begin
            s = 0;
            foreach (m_hist[k]) s += m_hist[k];
            dd = int'(din) - s;
            r  = (dd < 0) ? 0 : (dd > (1 << DW) - 1) ? (1 << DW) - 1 : dd;
            if (r != dd) m_fault = 1;
            for (int k = TAPS - 2; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = r;
            m_dout  = r;
            m_dv    = 1;
            m_count = (m_count + 1) % 65536;
        end else begin
            m_dv = 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_dout_valid", 32'(dout_valid), 32'(m_dv));
            check("cyc_dout", 32'(dout), 32'(m_dout));
            check("cyc_err", 32'(err), 32'(m_fault));
            check("cyc_count", 32'(count), 32'(m_count));
            if (dout_valid) got.push_back(int'(dout));
        end
    end

    task automatic step(input bit v, input int x, input bit rs);
        din_valid = v;
        din       = OW'(x);
        resync    = rs;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        resync    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        got.delete();
    endtask

    task automatic check_got(input string name, input int exp [$]);
        check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < got.size()) check(name, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    int stream [5] = '{5, 15, 27, 42, 53};

    initial begin
        // Loopback
        do_reset();
        check("reset_count", 32'(count), 0);
        check("reset_err", 32'(err), 0);
        check("reset_dout", 32'(dout), 0);
        foreach (stream[i]) step(1, stream[i], 0);
        step(0, 0, 0);
        check_got("loop_seq", '{5, 10, 12, 15, 16});
        check("loop_err", 32'(err), 0);
        check("loop_count", 32'(count), 5);

        // Valid gaps
        do_reset();
        foreach (stream[i]) begin
            step(1, stream[i], 0);
            repeat (3) step(0, 0, 0);
            if (i == 1) begin
                check("gap_hold_dout", 32'(dout), 10);
                check("gap_hold_dv", 32'(dout_valid), 0);
            end
        end
        check_got("gap_seq", '{5, 10, 12, 15, 16});

        // Underflow
        do_reset();
        step(1, 5, 0);
        step(1, 2, 0);
        check("under_dout", 32'(dout), 0);
        check("under_dv", 32'(dout_valid), 1);
        check("under_err", 32'(err), 1);
        step(1, 100, 0);
        check("under_fault_dv", 32'(dout_valid), 0);
        check("under_fault_dout", 32'(dout), 0);
        check("under_count", 32'(count), 2);

        // Overflow and resync
        do_reset();
        step(1, 300, 0);
        check("over_dout", 32'(dout), 255);
        check("over_err", 32'(err), 1);
        step(1, 7, 1);
        check("resync_dv", 32'(dout_valid), 0);
        check("resync_err", 32'(err), 0);
        check("resync_count", 32'(count), 0);
        step(1, 7, 0);
        check("post_resync_dout", 32'(dout), 7);
        check("post_resync_dv", 32'(dout_valid), 1);

        // Reset mid-stream
        do_reset();
        step(1, 5, 0);
        step(1, 15, 0);
        rst = 1'b1;
        step(1, 33, 0);
        rst = 1'b0;
        check("midrst_dout", 32'(dout), 0);
        check("midrst_dv", 32'(dout_valid), 0);
        check("midrst_count", 32'(count), 0);
        step(1, 10, 0);
        check("midrst_next", 32'(dout), 10);

        // Count wrap
        do_reset();
        repeat (65535) step(1, 0, 0);
        check("wrap_max", 32'(count), 32'hFFFF);
        step(1, 0, 0);
        check("wrap_zero", 32'(count), 0);
        check("wrap_err", 32'(err), 0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
